picorv32_memif_axil_bridge: RTL and testbench
=============================================

# picorv32_memif_axil_bridge

Registered bridge from the PicoRV32 native memory handshake to an AXI4-Lite master port. It sits directly downstream of the core memory interface. It consumes `mem_valid`, `mem_instr`, `mem_addr`, `mem_wdata` and `mem_wstrb`, and returns `mem_ready` and `mem_rdata` once the AXI transaction completes. It supports one outstanding transaction at a time. All AXI outputs are flop-driven to ease timing closure toward the interconnect.

## Interface
Parameters:
- none; all widths are fixed at 32-bit address/data, 4-bit strobe.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  native request valid; held by the core until `mem_ready`.
- `mem_instr`  in  1  request is an instruction fetch.
- `mem_addr`  in  32  byte address.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte enables; 0 means read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data; valid while `mem_ready` is 1.
- `bus_err`  out  1  one-cycle pulse coincident with `mem_ready` when the response is not OKAY.
- `m_axi_awvalid`  out  1  / `m_axi_awready`  in  1  / `m_axi_awaddr`  out  32  / `m_axi_awprot`  out  3  write address channel.
- `m_axi_wvalid`  out  1  / `m_axi_wready`  in  1  / `m_axi_wdata`  out  32  / `m_axi_wstrb`  out  4  write data channel.
- `m_axi_bvalid`  in  1  / `m_axi_bready`  out  1  / `m_axi_bresp`  in  2  write response channel.
- `m_axi_arvalid`  out  1  / `m_axi_arready`  in  1  / `m_axi_araddr`  out  32  / `m_axi_arprot`  out  3  read address channel.
- `m_axi_rvalid`  in  1  / `m_axi_rready`  out  1  / `m_axi_rdata`  in  32  / `m_axi_rresp`  in  2  read data channel.

## Operation
- **States:** IDLE, RD, WR, WRESP, DONE.
- **IDLE:** on `mem_valid`=1, capture the request into holding registers.
  - Address is word-aligned: `{mem_addr[31:2],2'b00}`.
  - Prot is 3'b100 if `mem_instr`, else 3'b000.
  - If `mem_wstrb`==0, go to RD; otherwise go to WR.
- **RD:**
  - `arvalid`=1 until the AR handshake (`arvalid` & `arready`), then 0.
  - `rready`=1 for the whole state.
  - On `rvalid` & `rready`: capture `rdata` into `mem_rdata`, set the error flag to (`rresp`!=0), go to DONE.
- **WR:**
  - `awvalid` and `wvalid` are each asserted on entry.
  - Each drops independently after its own handshake; they may complete in either order or in the same cycle.
  - When both are done, go to WRESP with `bready`=1.
- **WRESP:** on `bvalid`, set the error flag to (`bresp`!=0), go to DONE. `mem_rdata` is not updated by writes.
- **DONE:**
  - `mem_ready`=1 and `bus_err`=error flag, for exactly one cycle.
  - Next state is IDLE unconditionally. `mem_valid` sampled during DONE is ignored, since the core drops it on this edge.
- **Write-data independence:** AXI `wdata`/`wstrb` come from the holding registers. Changes on the native inputs after capture have no effect.
- **Ordering:** no `arvalid` and `awvalid` in the same transaction; at most one of RD/WR is ever active.
- **Reset:** may assert mid-transaction. All state is cleared and the FSM returns to IDLE; the outstanding AXI transaction is abandoned. This is acceptable because reset is system-wide.

## Timing
- **Reset values:**
  - `mem_ready`=0, `mem_rdata`=0, `bus_err`=0.
  - All AXI valid/ready outputs are 0.
  - All AXI addr/data/strb/prot outputs are 0.
- **Read latency:** `mem_valid` rises in cycle 0.
  - `arvalid` is high from cycle 1.
  - With zero-wait slave (`arready` in cycle 1, `rvalid` in cycle 2), `mem_ready` is high in cycle 3.
  - Each slave stall cycle adds exactly one cycle.
- **Write latency:** `awvalid`/`wvalid` high from cycle 1.
  - With both accepted in cycle 1 and `bvalid` in cycle 2, `mem_ready` is high in cycle 3.
- **Back-to-back:** earliest next-request capture is the cycle after DONE, i.e. a 4-cycle minimum period per transaction.
- **AXI compliance:** valids never drop before their handshake; payload is stable while valid is high.

## Test plan
- **Zero-wait read:** `mem_addr`=0x1000_0006, `mem_wstrb`=0, `mem_instr`=1; slave `rdata`=0xCAFE_F00D.
  - Required: `araddr`=0x1000_0004, `arprot`=3'b100.
  - Required: `mem_ready` pulses in cycle 3 with `mem_rdata`=0xCAFE_F00D, `bus_err`=0.
- **Split write channels:** write 0x1234_5678, `wstrb`=4'b0011 to 0x2000_0000; `wready` delayed 3 cycles after `awready`.
  - Required: `awvalid` drops after its handshake while `wvalid` stays high.
  - Required: `bready` only after both handshakes; `mem_ready` pulses once.
- **Read stalls:** `arready` low 5 cycles, then `rvalid` 4 cycles later.
  - Required: `mem_ready` in cycle 3+5+4=12; `araddr` stable throughout.
- **Error responses:** `bresp`=2'b10 on a write, then `rresp`=2'b11 on a read.
  - Required: `bus_err`=1 coincident with each `mem_ready`; `mem_rdata` still reflects `rdata` on the read.
- **Back-to-back traffic:** fetch, load, store issued consecutively.
  - Required: a single `mem_ready` per request; no AXI valid asserted in DONE or IDLE.
- **Reset mid-read:** drop `resetn` while `arvalid`=1.
  - Required: all outputs go to 0 asynchronously; after release, a new read completes normally.

Source files
------------

// File: rtl/picorv32_memif_axil_bridge.sv
// PicoRV32 native memory port to AXI4-Lite master bridge.
// One transaction in flight; every AXI-facing output comes straight from a flop.
module picorv32_memif_axil_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp
);

  typedef enum logic [2:0] {IDLE, RD, WR, WRESP, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [2:0]  prot_q;
  logic        aw_done, w_done;

  // A channel counts as done once its registered valid has been retired.
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;
  assign m_axi_awprot = prot_q;
  assign m_axi_arprot = prot_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_valid) state_nxt = (mem_wstrb == 4'b0000) ? RD : WR;
      RD:      if (m_axi_rvalid && m_axi_rready) state_nxt = DONE;
      WR:      if (aw_done && w_done) state_nxt = WRESP;
      WRESP:   if (m_axi_bvalid && m_axi_bready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_ready     <= 1'b0;
      mem_rdata     <= 32'h0;
      bus_err       <= 1'b0;
      addr_q        <= 32'h0;
      prot_q        <= 3'b000;
      m_axi_wdata   <= 32'h0;
      m_axi_wstrb   <= 4'h0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        IDLE: if (mem_valid) begin
          addr_q      <= {mem_addr[31:2], 2'b00};
          prot_q      <= mem_instr ? 3'b100 : 3'b000;
          m_axi_wdata <= mem_wdata;
          m_axi_wstrb <= mem_wstrb;
          if (mem_wstrb == 4'b0000) begin
            m_axi_arvalid <= 1'b1;
            m_axi_rready  <= 1'b1;
          end else begin
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
          end
        end
        RD: begin
          if (m_axi_arready) m_axi_arvalid <= 1'b0;
          if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rready <= 1'b0;
            mem_rdata    <= m_axi_rdata;
            bus_err      <= (m_axi_rresp != 2'b00);
            mem_ready    <= 1'b1;
          end
        end
        WR: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (aw_done && w_done) m_axi_bready <= 1'b1;
        end
        WRESP: if (m_axi_bvalid && m_axi_bready) begin
          m_axi_bready <= 1'b0;
          bus_err      <= (m_axi_bresp != 2'b00);
          mem_ready    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_picorv32_memif_axil_bridge.sv
// Scoreboarded bench for the PicoRV32 -> AXI4-Lite bridge with a cycle-stepped slave model.
module tb_picorv32_memif_axil_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, bus_err;
  logic [31:0] mem_rdata;
  logic        m_axi_awvalid, m_axi_awready;
  logic [31:0] m_axi_awaddr;
  logic [2:0]  m_axi_awprot;
  logic        m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_arvalid, m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid, m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;

  always #5 clk = ~clk;

  picorv32_memif_axil_bridge dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          passed = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic clear_slave();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid = 1'b0;  m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0;
    m_axi_rdata = 32'h0;  m_axi_rresp = 2'b00;
  endtask

  task automatic test_reset();
    logic [144:0] outs;
    resetn = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    clear_slave();
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {mem_ready, mem_rdata, bus_err, m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
            m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_bready, m_axi_arvalid,
            m_axi_araddr, m_axi_arprot, m_axi_rready};
    total++;
    if (outs !== '0) $display("FAIL reset_values got=%h want=0", outs); else passed++;
    resetn = 1'b1;
    last_rdata = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input string nm, input logic [31:0] a, input logic instr,
                         input logic [31:0] rd, input logic [1:0] resp,
                         input int ar_st, input int r_st);
    exp_t        e;
    int          ar_hs = -1;
    bit          r_hs = 0;
    bit          done = 0;
    logic [31:0] ea;
    logic [2:0]  eprot;
    ea = {a[31:2], 2'b00};
    eprot = instr ? 3'b100 : 3'b000;
    e.rdata = rd; e.err = (resp != 2'b00); e.lat = 3 + ar_st + r_st;
    sb.push_back(e);
    mem_valid = 1'b1; mem_instr = instr; mem_addr = a; mem_wstrb = 4'h0; mem_wdata = $urandom;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        m_axi_arready = (ar_hs < 0 && c >= 1 + ar_st);
        m_axi_rvalid  = (ar_hs >= 0 && !r_hs && c >= ar_hs + 1 + r_st);
        m_axi_rdata   = m_axi_rvalid ? rd : 32'hDEAD_BEEF;
        m_axi_rresp   = m_axi_rvalid ? resp : 2'b00;
      end
      @(negedge clk);
      if (c == 0) begin
        total++;
        if ({mem_ready, bus_err, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid} !== 5'b0)
          $display("FAIL %s idle_quiet got=%b want=00000", nm,
                   {mem_ready, bus_err, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid});
        else passed++;
      end else if (!mem_ready) begin
        total++;
        if (m_axi_arvalid !== (ar_hs < 0))
          $display("FAIL %s arvalid c=%0d got=%b want=%b", nm, c, m_axi_arvalid, ar_hs < 0);
        else passed++;
        total++;
        if ({m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready} !== 4'b1000)
          $display("FAIL %s rd_handshakes c=%0d got=%b want=1000", nm, c,
                   {m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready});
        else passed++;
        total++;
        if ({m_axi_araddr, m_axi_arprot} !== {ea, eprot})
          $display("FAIL %s ar_payload c=%0d got=%h/%b want=%h/%b", nm, c,
                   m_axi_araddr, m_axi_arprot, ea, eprot);
        else passed++;
      end
      if (m_axi_arvalid && m_axi_arready) ar_hs = c;
      if (m_axi_rvalid && m_axi_rready) r_hs = 1;
      if (mem_ready) begin
        done = 1;
        total++;
        if (sb.size() == 0) $display("FAIL %s sb_empty got=ready want=none", nm);
        else begin
          passed++;
          e = sb.pop_front();
          total++;
          if (c !== e.lat) $display("FAIL %s latency got=%0d want=%0d", nm, c, e.lat);
          else passed++;
          total++;
          if ({mem_rdata, bus_err} !== {e.rdata, e.err})
            $display("FAIL %s rdata_err got=%h/%b want=%h/%b", nm, mem_rdata, bus_err, e.rdata, e.err);
          else passed++;
          last_rdata = e.rdata;
        end
        total++;
        if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready} !== 5'b0)
          $display("FAIL %s done_quiet got=%b want=00000", nm,
                   {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready});
        else passed++;
      end
    end
    if (!done) begin
      total++;
      $display("FAIL %s timeout got=no_ready want=ready", nm);
      void'(sb.pop_front());
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    clear_slave();
  endtask

  task automatic do_write(input string nm, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [1:0] resp,
                          input int aw_st, input int w_st, input int b_st);
    exp_t        e;
    int          aw_hs = -1;
    int          w_hs = -1;
    int          both;
    bit          b_hs = 0;
    bit          done = 0;
    logic [31:0] ea;
    ea = {a[31:2], 2'b00};
    both = (aw_st > w_st) ? 1 + aw_st : 1 + w_st;
    e.rdata = last_rdata; e.err = (resp != 2'b00); e.lat = both + 2 + b_st;
    sb.push_back(e);
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 1) begin
          // native inputs must not leak into the captured request
          mem_wdata = ~wd; mem_addr = ~a; mem_wstrb = ~ws;
        end
        m_axi_awready = (aw_hs < 0 && c >= 1 + aw_st);
        m_axi_wready  = (w_hs < 0 && c >= 1 + w_st);
        m_axi_bvalid  = (aw_hs >= 0 && w_hs >= 0 && !b_hs &&
                         c >= ((aw_hs > w_hs) ? aw_hs : w_hs) + 1 + b_st);
        m_axi_bresp   = m_axi_bvalid ? resp : 2'b00;
      end
      @(negedge clk);
      if (c == 0) begin
        total++;
        if ({mem_ready, bus_err, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid} !== 5'b0)
          $display("FAIL %s idle_quiet got=%b want=00000", nm,
                   {mem_ready, bus_err, m_axi_arvalid, m_axi_awvalid, m_axi_wvalid});
        else passed++;
      end else if (!mem_ready) begin
        total++;
        if ({m_axi_awvalid, m_axi_wvalid} !== {aw_hs < 0, w_hs < 0})
          $display("FAIL %s aw_w_valid c=%0d got=%b%b want=%b%b", nm, c,
                   m_axi_awvalid, m_axi_wvalid, aw_hs < 0, w_hs < 0);
        else passed++;
        total++;
        if (m_axi_bready !== (aw_hs >= 0 && w_hs >= 0))
          $display("FAIL %s bready c=%0d got=%b want=%b", nm, c, m_axi_bready, aw_hs >= 0 && w_hs >= 0);
        else passed++;
        total++;
        if ({m_axi_arvalid, m_axi_rready} !== 2'b00)
          $display("FAIL %s no_read_side c=%0d got=%b want=00", nm, c, {m_axi_arvalid, m_axi_rready});
        else passed++;
        total++;
        if ({m_axi_awaddr, m_axi_awprot, m_axi_wdata, m_axi_wstrb} !== {ea, 3'b000, wd, ws})
          $display("FAIL %s w_payload c=%0d got=%h/%b/%h/%h want=%h/000/%h/%h", nm, c,
                   m_axi_awaddr, m_axi_awprot, m_axi_wdata, m_axi_wstrb, ea, wd, ws);
        else passed++;
      end
      if (m_axi_awvalid && m_axi_awready) aw_hs = c;
      if (m_axi_wvalid && m_axi_wready) w_hs = c;
      if (m_axi_bvalid && m_axi_bready) b_hs = 1;
      if (mem_ready) begin
        done = 1;
        total++;
        if (sb.size() == 0) $display("FAIL %s sb_empty got=ready want=none", nm);
        else begin
          passed++;
          e = sb.pop_front();
          total++;
          if (c !== e.lat) $display("FAIL %s latency got=%0d want=%0d", nm, c, e.lat);
          else passed++;
          total++;
          if ({mem_rdata, bus_err} !== {e.rdata, e.err})
            $display("FAIL %s rdata_err got=%h/%b want=%h/%b", nm, mem_rdata, bus_err, e.rdata, e.err);
          else passed++;
        end
        total++;
        if ({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready} !== 5'b0)
          $display("FAIL %s done_quiet got=%b want=00000", nm,
                   {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready});
        else passed++;
      end
    end
    if (!done) begin
      total++;
      $display("FAIL %s timeout got=no_ready want=ready", nm);
      void'(sb.pop_front());
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    clear_slave();
  endtask

  task automatic test_zero_wait_read();
    do_read("zw_read", 32'h1000_0006, 1'b1, 32'hCAFE_F00D, 2'b00, 0, 0);
  endtask

  task automatic test_split_write();
    do_write("split_wr", 32'h2000_0000, 32'h1234_5678, 4'b0011, 2'b00, 0, 3, 0);
    do_write("split_aw", 32'h2000_0013, 32'hA5A5_0F0F, 4'b1100, 2'b00, 2, 0, 1);
  endtask

  task automatic test_read_stalls();
    do_read("rd_stall", 32'h0000_8001, 1'b0, 32'h0BAD_CAFE, 2'b00, 5, 4);
  endtask

  task automatic test_errors();
    do_write("err_wr", 32'h4000_0010, 32'hFFFF_0000, 4'b1111, 2'b10, 0, 0, 0);
    do_read("err_rd", 32'h4000_0014, 1'b0, 32'h5555_AAAA, 2'b11, 0, 0);
  endtask

  task automatic test_back_to_back();
    do_read("b2b_fetch", 32'h0000_0100, 1'b1, 32'h0010_0093, 2'b00, 0, 0);
    do_read("b2b_load", 32'h0000_2002, 1'b0, 32'h7654_3210, 2'b00, 1, 0);
    do_write("b2b_store", 32'h0000_3007, 32'hDEAD_0001, 4'b1000, 2'b00, 0, 0, 0);
    do_read("b2b_fetch2", 32'h0000_0104, 1'b1, 32'h0020_0113, 2'b00, 0, 2);
  endtask

  task automatic test_reset_mid_read();
    logic [144:0] outs;
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h3000_0008; mem_wstrb = 4'h0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (m_axi_arvalid !== 1'b1) $display("FAIL rst_mid arvalid_before got=%b want=1", m_axi_arvalid);
    else passed++;
    #2 resetn = 1'b0;
    #1;
    outs = {mem_ready, mem_rdata, bus_err, m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
            m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_bready, m_axi_arvalid,
            m_axi_araddr, m_axi_arprot, m_axi_rready};
    total++;
    if (outs !== '0) $display("FAIL rst_mid async_clear got=%h want=0", outs); else passed++;
    mem_valid = 1'b0;
    last_rdata = 32'h0;
    @(posedge clk);
    @(negedge clk); #2 resetn = 1'b1;
    @(posedge clk); #1;
    do_read("post_rst", 32'h3000_000C, 1'b0, 32'h1357_9BDF, 2'b00, 0, 1);
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_split_write();
    test_read_stalls();
    test_errors();
    test_back_to_back();
    test_reset_mid_read();
    total++;
    if (sb.size() != 0) $display("FAIL sb_drain got=%0d want=0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
